// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : Pipeline memory-access stage owning the data-memory port; checks
//            alignment, builds strobes/store data, extends loads, times out.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic [31:0]         in_pc,
  output logic                dreq,
  output logic                dwr,
  output logic [ADDR_W-1:0]   daddr,
  output logic [1:0]          dsize,
  output logic [DATA_W/8-1:0] dstrb,
  output logic [DATA_W-1:0]   dwdata,
  input  logic                daddr_ok,
  input  logic                ddata_ok,
  input  logic [DATA_W-1:0]   drdata,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [31:0]         out_pc,
  output logic                out_exc,
  output logic [4:0]          out_exc_code,
  output logic [ADDR_W-1:0]   out_badvaddr
);

  localparam int c_strb_w = DATA_W / 8;
  localparam int c_off_w  = $clog2(c_strb_w);
  localparam int c_cnt_w  = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd8:  return 2'd0;
      4'd3, 4'd4, 4'd9:  return 2'd1;
      4'd5, 4'd6, 4'd10: return 2'd2;
      default:           return 2'd3;
    endcase
  endfunction

  state_t               r_state, w_nxt_state;
  logic [3:0]           r_op;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [31:0]          r_pc;
  logic [c_cnt_w-1:0]   r_cnt, w_nxt_cnt;
  logic                 r_dbe, w_nxt_dbe;
  logic                 w_latch;
  logic [DATA_W-1:0]    w_nxt_data;
  logic [31:0]          w_nxt_pc;
  logic                 w_nxt_exc;
  logic [4:0]           w_nxt_code;
  logic [ADDR_W-1:0]    w_nxt_bad;

  logic [1:0]           w_in_size, w_size;
  logic                 w_in_ri, w_in_mis;
  logic [c_off_w-1:0]   w_off;
  logic [3:0]           w_bytes;
  logic [c_strb_w-1:0]  w_mask, w_strb;
  logic [DATA_W-1:0]    w_wrep, w_shift, w_load;

  // Accept-time classification
  assign w_in_size = op_size(in_op);
  assign w_in_ri   = (in_op >= 4'd12) ||
                     ((DATA_W == 32) && (in_op == 4'd6 || in_op == 4'd7 || in_op == 4'd11));

  always_comb begin
    w_in_mis = 1'b0;
    case (w_in_size)
      2'd0:    w_in_mis = 1'b0;
      2'd1:    w_in_mis = in_addr[0];
      2'd2:    w_in_mis = |in_addr[1:0];
      default: w_in_mis = |in_addr[2:0];
    endcase
    if (in_op == 4'd0) w_in_mis = 1'b0;
  end

  // Bus-side datapath from the latched op
  assign w_size  = op_size(r_op);
  assign w_off   = r_addr[c_off_w-1:0];
  assign w_bytes = 4'd1 << w_size;
  assign w_mask  = (c_strb_w'(1) << w_bytes) - c_strb_w'(1);
  assign w_strb  = w_mask << w_off;
  assign w_shift = drdata >> {w_off, 3'b000};

  always_comb begin
    w_wrep = r_wdata;
    case (w_size)
      2'd0:    w_wrep = {(DATA_W/8){r_wdata[7:0]}};
      2'd1:    w_wrep = {(DATA_W/16){r_wdata[15:0]}};
      2'd2:    w_wrep = {(DATA_W/32){r_wdata[31:0]}};
      default: w_wrep = r_wdata;
    endcase
  end

  always_comb begin
    w_load = w_shift;
    case (r_op)
      4'd1:    w_load = DATA_W'($signed(w_shift[7:0]));
      4'd2:    w_load = DATA_W'(w_shift[7:0]);
      4'd3:    w_load = DATA_W'($signed(w_shift[15:0]));
      4'd4:    w_load = DATA_W'(w_shift[15:0]);
      4'd5:    w_load = DATA_W'($signed(w_shift[31:0]));
      4'd6:    w_load = DATA_W'(w_shift[31:0]);
      default: w_load = w_shift;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE) && resetn;
  assign dreq      = (r_state == S_REQ);
  assign dwr       = dreq && r_op[3];
  assign daddr     = dreq ? r_addr : '0;
  assign dsize     = dreq ? w_size : 2'd0;
  assign dstrb     = dreq ? w_strb : '0;
  assign dwdata    = (dreq && r_op[3]) ? w_wrep : '0;
  assign out_valid = ((r_state == S_RESP) && !flush) || r_dbe;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_dbe   = 1'b0;
    w_latch     = 1'b0;
    w_nxt_data  = out_data;
    w_nxt_pc    = out_pc;
    w_nxt_exc   = out_exc;
    w_nxt_code  = out_exc_code;
    w_nxt_bad   = out_badvaddr;
    case (r_state)
      S_IDLE: begin
        if (in_valid && !flush) begin
          if (w_in_ri || w_in_mis || in_op == 4'd0) begin
            w_nxt_state = S_RESP;
            w_nxt_pc    = in_pc;
            w_nxt_data  = '0;
            w_nxt_exc   = 1'b0;
            w_nxt_code  = 5'd0;
            w_nxt_bad   = '0;
            if (w_in_ri) begin
              w_nxt_exc  = 1'b1;
              w_nxt_code = 5'd10;
            end else if (w_in_mis) begin
              w_nxt_exc  = 1'b1;
              w_nxt_code = in_op[3] ? 5'd5 : 5'd4;
              w_nxt_bad  = in_addr;
            end else begin
              w_nxt_data = DATA_W'(in_addr);
            end
          end else begin
            w_nxt_state = S_REQ;
            w_latch     = 1'b1;
          end
        end
      end
      S_REQ: begin
        // An address phase already accepted must still see its data phase
        if (flush) begin
          w_nxt_state = daddr_ok ? S_DRAIN : S_IDLE;
        end else if (daddr_ok) begin
          w_nxt_state = S_WAIT;
          w_nxt_cnt   = '0;
        end
      end
      S_WAIT: begin
        w_nxt_cnt = r_cnt + c_cnt_w'(1);
        if (flush) begin
          w_nxt_state = ddata_ok ? S_IDLE : S_DRAIN;
        end else if (ddata_ok) begin
          w_nxt_state = S_RESP;
          w_nxt_data  = r_op[3] ? '0 : w_load;
          w_nxt_pc    = r_pc;
          w_nxt_exc   = 1'b0;
          w_nxt_code  = 5'd0;
          w_nxt_bad   = '0;
        end else if (r_cnt == c_cnt_w'(MAX_WAIT - 1)) begin
          w_nxt_state = S_DRAIN;
          w_nxt_dbe   = 1'b1;
          w_nxt_data  = '0;
          w_nxt_pc    = r_pc;
          w_nxt_exc   = 1'b1;
          w_nxt_code  = 5'd7;
          w_nxt_bad   = '0;
        end
      end
      S_RESP:  w_nxt_state = S_IDLE;
      S_DRAIN: if (ddata_ok) w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nxt_state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_op         <= 4'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pc         <= 32'd0;
      r_cnt        <= '0;
      r_dbe        <= 1'b0;
      out_data     <= '0;
      out_pc       <= 32'd0;
      out_exc      <= 1'b0;
      out_exc_code <= 5'd0;
      out_badvaddr <= '0;
    end else begin
      r_cnt        <= w_nxt_cnt;
      r_dbe        <= w_nxt_dbe;
      out_data     <= w_nxt_data;
      out_pc       <= w_nxt_pc;
      out_exc      <= w_nxt_exc;
      out_exc_code <= w_nxt_code;
      out_badvaddr <= w_nxt_bad;
      if (w_latch) begin
        r_op    <= in_op;
        r_addr  <= in_addr;
        r_wdata <= in_wdata;
        r_pc    <= in_pc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Brief    : Scoreboard bench for mem_access_stage, 32-bit and 64-bit instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
  } exp_t;
  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  // 32-bit instance (a_*)
  logic a_flush, a_valid, a_ready, a_dreq, a_dwr, a_aok, a_dok, a_ovalid, a_oexc;
  logic [3:0]  a_op, a_dstrb;
  logic [1:0]  a_dsize;
  logic [4:0]  a_ocode;
  logic [31:0] a_addr, a_wdata, a_pc, a_daddr, a_dwdata, a_rdata, a_odata, a_opc, a_obad;
  // 64-bit instance (b_*)
  logic b_flush, b_valid, b_ready, b_dreq, b_dwr, b_aok, b_dok, b_ovalid, b_oexc;
  logic [3:0]  b_op;
  logic [7:0]  b_dstrb;
  logic [1:0]  b_dsize;
  logic [4:0]  b_ocode;
  logic [31:0] b_addr, b_pc, b_daddr, b_opc, b_obad;
  logic [63:0] b_wdata, b_dwdata, b_rdata, b_odata;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut32 (
    .clk(clk), .resetn(resetn), .flush(a_flush), .in_valid(a_valid), .in_ready(a_ready),
    .in_op(a_op), .in_addr(a_addr), .in_wdata(a_wdata), .in_pc(a_pc),
    .dreq(a_dreq), .dwr(a_dwr), .daddr(a_daddr), .dsize(a_dsize), .dstrb(a_dstrb),
    .dwdata(a_dwdata), .daddr_ok(a_aok), .ddata_ok(a_dok), .drdata(a_rdata),
    .out_valid(a_ovalid), .out_data(a_odata), .out_pc(a_opc), .out_exc(a_oexc),
    .out_exc_code(a_ocode), .out_badvaddr(a_obad));

  mem_access_stage #(.DATA_W(64), .ADDR_W(32), .MAX_WAIT(4)) dut64 (
    .clk(clk), .resetn(resetn), .flush(b_flush), .in_valid(b_valid), .in_ready(b_ready),
    .in_op(b_op), .in_addr(b_addr), .in_wdata(b_wdata), .in_pc(b_pc),
    .dreq(b_dreq), .dwr(b_dwr), .daddr(b_daddr), .dsize(b_dsize), .dstrb(b_dstrb),
    .dwdata(b_dwdata), .daddr_ok(b_aok), .ddata_ok(b_dok), .drdata(b_rdata),
    .out_valid(b_ovalid), .out_data(b_odata), .out_pc(b_opc), .out_exc(b_oexc),
    .out_exc_code(b_ocode), .out_badvaddr(b_obad));

  // Monitors: every result pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (resetn && a_ovalid) begin
      n_tests++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL sb32 unexpected out_valid data=%h pc=%h code=%0d", a_odata, a_opc, a_ocode);
      end else begin
        e32 = q32.pop_front();
        if ({32'd0, a_odata, a_opc, a_oexc, a_ocode, a_obad} !== e32) begin
          n_fail++;
          $display("FAIL sb32 got data=%h pc=%h exc=%b code=%0d bad=%h required data=%h pc=%h exc=%b code=%0d bad=%h",
                   a_odata, a_opc, a_oexc, a_ocode, a_obad, e32.data, e32.pc, e32.exc, e32.code, e32.bad);
        end
      end
    end
    if (resetn && b_ovalid) begin
      n_tests++;
      if (q64.size() == 0) begin
        n_fail++;
        $display("FAIL sb64 unexpected out_valid data=%h pc=%h code=%0d", b_odata, b_opc, b_ocode);
      end else begin
        e64 = q64.pop_front();
        if ({b_odata, b_opc, b_oexc, b_ocode, b_obad} !== e64) begin
          n_fail++;
          $display("FAIL sb64 got data=%h pc=%h exc=%b code=%0d bad=%h required data=%h pc=%h exc=%b code=%0d bad=%h",
                   b_odata, b_opc, b_oexc, b_ocode, b_obad, e64.data, e64.pc, e64.exc, e64.code, e64.bad);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input bit w, input logic [63:0] d, input logic [31:0] pc,
                      input logic exc, input logic [4:0] code, input logic [31:0] bad);
    if (w) q64.push_back({d, pc, exc, code, bad});
    else   q32.push_back({d, pc, exc, code, bad});
  endtask

  // Returns one cycle after the accepting edge
  task automatic issue(input bit w, input logic [3:0] op, input logic [31:0] addr,
                       input logic [63:0] wd, input logic [31:0] pc);
    int n = 0;
    if (w) begin b_op = op; b_addr = addr; b_wdata = wd; b_pc = pc; b_valid = 1'b1; end
    else   begin a_op = op; a_addr = addr; a_wdata = wd[31:0]; a_pc = pc; a_valid = 1'b1; end
    while (!(w ? b_ready : a_ready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("issue_in_ready_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // Address accepted in the first dreq cycle, data after `waits` WAIT cycles
  task automatic mem(input bit w, input int waits, input logic [63:0] rdata);
    int n = 0;
    while (!(w ? b_dreq : a_dreq) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("dreq_seen", 64'(w ? b_dreq : a_dreq), 64'd1);
    if (w) b_aok = 1'b1; else a_aok = 1'b1;
    @(posedge clk); #1;
    a_aok = 1'b0; b_aok = 1'b0;
    repeat (waits) begin @(posedge clk); #1; end
    if (w) begin b_dok = 1'b1; b_rdata = rdata; end
    else   begin a_dok = 1'b1; a_rdata = rdata[31:0]; end
    @(posedge clk); #1;
    a_dok = 1'b0; b_dok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0;
    {a_flush, a_valid, a_aok, a_dok, a_op, a_addr, a_wdata, a_pc, a_rdata} = '0;
    {b_flush, b_valid, b_aok, b_dok, b_op, b_addr, b_wdata, b_pc, b_rdata} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(a_ready), 64'd0);
    chk("rst_dreq", 64'(a_dreq), 64'd0);
    chk("rst_out", {a_ovalid, a_oexc, a_odata, a_opc}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(a_ready), 64'd1);

    // LB 0x1003: byte 0x80 sign-extended
    push(0, 64'hFFFF_FF80, 32'h100, 0, 0, 0);
    issue(0, 4'd1, 32'h1003, 0, 32'h100);
    chk("lb_dstrb", 64'(a_dstrb), 64'h8);
    chk("lb_dwr_dsize", {a_dwr, a_dsize}, 64'd0);
    chk("lb_daddr", 64'(a_daddr), 64'h1003);
    mem(0, 1, 32'h80FF_1234);
    chk("lb_out_valid", 64'(a_ovalid), 64'd1);
    @(posedge clk); #1;
    chk("lb_single_pulse", 64'(a_ovalid), 64'd0);

    push(0, 64'h12, 32'h104, 0, 0, 0);
    issue(0, 4'd2, 32'h1001, 0, 32'h104);
    mem(0, 0, 32'h80FF_1234);
    // LH with data on the last permitted WAIT cycle
    push(0, 64'hFFFF_80FF, 32'h108, 0, 0, 0);
    issue(0, 4'd3, 32'h1002, 0, 32'h108);
    chk("lh_dstrb", 64'(a_dstrb), 64'hC);
    mem(0, 3, 32'h80FF_1234);
    push(0, 64'h80FF_1234, 32'h10C, 0, 0, 0);
    issue(0, 4'd5, 32'h1000, 0, 32'h10C);
    chk("lw_dstrb", 64'(a_dstrb), 64'hF);
    mem(0, 2, 32'h80FF_1234);

    push(0, 64'd0, 32'h110, 0, 0, 0);
    issue(0, 4'd9, 32'h2002, 64'h0000_ABCD, 32'h110);
    chk("sh_dstrb", 64'(a_dstrb), 64'hC);
    chk("sh_dwdata", 64'(a_dwdata), 64'hABCD_ABCD);
    chk("sh_dwr_dsize", {a_dwr, a_dsize}, 64'b101);
    mem(0, 0, 32'h0);
    push(0, 64'd0, 32'h114, 0, 0, 0);
    issue(0, 4'd8, 32'h3001, 64'h5A, 32'h114);
    chk("sb_dstrb", 64'(a_dstrb), 64'h2);
    chk("sb_dwdata", 64'(a_dwdata), 64'h5A5A_5A5A);
    mem(0, 0, 32'h0);

    // Exceptions and NOP: one-cycle latency, no bus request
    push(0, 64'd0, 32'h118, 1, 5'd5, 32'h2001);
    issue(0, 4'd9, 32'h2001, 64'h0000_ABCD, 32'h118);
    chk("ades_latency", {a_ovalid, a_dreq}, 64'b10);
    push(0, 64'd0, 32'h11C, 1, 5'd4, 32'h1002);
    issue(0, 4'd5, 32'h1002, 0, 32'h11C);
    chk("adel_latency", {a_ovalid, a_dreq}, 64'b10);
    push(0, 64'd0, 32'h120, 1, 5'd10, 32'h0);
    issue(0, 4'd7, 32'h1000, 0, 32'h120);
    chk("ri_ld_latency", {a_ovalid, a_dreq}, 64'b10);
    push(0, 64'd0, 32'h124, 1, 5'd10, 32'h0);
    issue(0, 4'd12, 32'h1001, 0, 32'h124);
    push(0, 64'hDEAD_BEEF, 32'h128, 0, 0, 0);
    issue(0, 4'd0, 32'hDEAD_BEEF, 0, 32'h128);
    chk("nop_latency", {a_ovalid, a_dreq}, 64'b10);

    // Bus timeout: DBE after MAX_WAIT WAIT cycles, then drain
    push(0, 64'd0, 32'h400, 1, 5'd7, 32'h0);
    issue(0, 4'd5, 32'h4000, 0, 32'h400);
    a_aok = 1'b1;
    @(posedge clk); #1;
    a_aok = 1'b0;
    n = 0;
    while (!a_ovalid && n < 20) begin @(posedge clk); #1; n++; end
    chk("dbe_latency", 64'(n), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("drain_in_ready", {a_ready, a_ovalid}, 64'd0);
    end
    a_dok = 1'b1;
    @(posedge clk); #1;
    a_dok = 1'b0;
    chk("drain_exit_ready", 64'(a_ready), 64'd1);

    // Flush in WAIT then late data: no result
    issue(0, 4'd5, 32'h1000, 0, 32'h500);
    a_aok = 1'b1;
    @(posedge clk); #1;
    a_aok = 1'b0; a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    chk("flush_wait_drain", 64'(a_ready), 64'd0);
    a_dok = 1'b1;
    @(posedge clk); #1;
    a_dok = 1'b0;
    chk("flush_wait_idle", {a_ready, a_ovalid}, 64'b10);

    // Flush in REQ without address acceptance
    issue(0, 4'd5, 32'h1000, 0, 32'h504);
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    chk("flush_req", {a_dreq, a_ready}, 64'b01);

    // Reset during WAIT clears held outputs; late data ignored
    push(0, 64'h0000_1234, 32'h600, 0, 0, 0);
    issue(0, 4'd4, 32'h1000, 0, 32'h600);
    mem(0, 0, 32'h8000_1234);
    issue(0, 4'd5, 32'h1000, 0, 32'h604);
    a_aok = 1'b1;
    @(posedge clk); #1;
    a_aok = 1'b0; resetn = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_out", {a_dreq, a_ovalid, a_oexc, a_ready, a_odata, a_opc}, 64'd0);
    resetn = 1'b1; a_dok = 1'b1; a_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    a_dok = 1'b0;
    chk("rst_late_data", {a_ready, a_ovalid}, 64'b10);

    // 64-bit datapath
    push(1, 64'h0000_0000_FEDC_BA98, 32'h700, 0, 0, 0);
    issue(1, 4'd6, 32'h1004, 0, 32'h700);
    chk("lwu64_dstrb", 64'(b_dstrb), 64'hF0);
    mem(1, 1, 64'hFEDC_BA98_0000_0001);
    push(1, 64'hFFFF_FFFF_FEDC_BA98, 32'h704, 0, 0, 0);
    issue(1, 4'd5, 32'h1004, 0, 32'h704);
    mem(1, 0, 64'hFEDC_BA98_0000_0001);
    push(1, 64'h0123_4567_89AB_CDEF, 32'h708, 0, 0, 0);
    issue(1, 4'd7, 32'h1008, 0, 32'h708);
    chk("ld64_dstrb", 64'(b_dstrb), 64'hFF);
    mem(1, 2, 64'h0123_4567_89AB_CDEF);
    push(1, 64'd0, 32'h70C, 0, 0, 0);
    issue(1, 4'd11, 32'h2008, 64'h1122_3344_5566_7788, 32'h70C);
    chk("sd64_dwdata", b_dwdata, 64'h1122_3344_5566_7788);
    chk("sd64_ctl", {b_dwr, b_dsize, b_dstrb}, {53'd0, 1'b1, 2'd3, 8'hFF});
    mem(1, 0, 64'd0);
    push(1, 64'd0, 32'h710, 0, 0, 0);
    issue(1, 4'd10, 32'h200C, 64'hCAFE_F00D, 32'h710);
    chk("sw64_dstrb", 64'(b_dstrb), 64'hF0);
    chk("sw64_dwdata", b_dwdata, 64'hCAFE_F00D_CAFE_F00D);
    mem(1, 0, 64'd0);
    push(1, 64'd0, 32'h714, 1, 5'd4, 32'h1004);
    issue(1, 4'd7, 32'h1004, 0, 32'h714);
    chk("ld64_adel_latency", {b_ovalid, b_dreq}, 64'b10);

    repeat (5) @(posedge clk);
    #1;
    chk("sb32_drained", 64'(q32.size()), 64'd0);
    chk("sb64_drained", 64'(q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
